// File: rtl/deint_ctrl.sv
// Ping-pong buffer controller for a block deinterleaver.
// Fills one bank while the other drains; symbol length follows the modulation.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, stop, mod    : frame control; mod is latched at an accepted start
//   in_valid / in_ready : upstream coded-bit handshake
//   wr_en/wr_bank/wr_addr : buffer write side
//   rd_en/rd_bank/rd_addr : buffer read side, gated by out_ready
//   out_valid, sym_done : read data valid (1-cycle latency), last bit of symbol
//   busy                : frame in progress or data still in flight
module deint_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mod,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              sym_done,
    output logic              busy
);

    typedef enum logic {W_IDLE, W_FILL} w_state_e;
    typedef enum logic {R_IDLE, R_DRAIN} r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [1:0]        mod_q, mod_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] rcnt_q, rcnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic              out_valid_q, out_valid_d;
    logic              sym_done_q, sym_done_d;

    logic [ADDR_W-1:0] last_cnt;
    logic              start_ok;
    logic              wr_last;
    logic              rd_last;

    always_comb begin
        case (mod_q)
            2'd0:    last_cnt = ADDR_W'(47);
            2'd1:    last_cnt = ADDR_W'(95);
            2'd2:    last_cnt = ADDR_W'(191);
            default: last_cnt = ADDR_W'(287);
        endcase
    end

    assign busy = (w_state_q == W_FILL) | full_q[0] | full_q[1]
                | (r_state_q == R_DRAIN) | out_valid_q;

    assign in_ready = (w_state_q == W_FILL) & ~full_q[wr_bank_q];
    assign wr_en    = in_valid & in_ready;
    assign wr_bank  = wr_bank_q;
    assign wr_addr  = wcnt_q;

    assign rd_en    = (r_state_q == R_DRAIN) & out_ready;
    assign rd_bank  = rd_bank_q;
    assign rd_addr  = rcnt_q;

    assign out_valid = out_valid_q;
    assign sym_done  = sym_done_q;

    assign start_ok = start & ~busy;
    assign wr_last  = wr_en & (wcnt_q == last_cnt);
    assign rd_last  = rd_en & (rcnt_q == last_cnt);

    always_comb begin
        w_state_d   = w_state_q;
        r_state_d   = r_state_q;
        mod_d       = mod_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        out_valid_d = rd_en;
        sym_done_d  = rd_last;

        if (start_ok) begin
            w_state_d = W_FILL;
            mod_d     = mod;
            wcnt_d    = '0;
            rcnt_d    = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            full_d    = '0;
        end else begin
            if (wr_en) begin
                if (wr_last) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    wcnt_d            = '0;
                end else begin
                    wcnt_d = wcnt_q + ADDR_W'(1);
                end
            end

            // A partial bank is dropped; completed banks keep draining.
            if (stop && (w_state_q == W_FILL)) begin
                w_state_d = W_IDLE;
                wcnt_d    = '0;
            end

            // Set and clear always hit different banks, so both apply.
            case (r_state_q)
                R_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        r_state_d = R_DRAIN;
                    end
                end
                default: begin
                    if (rd_en) begin
                        if (rd_last) begin
                            full_d[rd_bank_q] = 1'b0;
                            rd_bank_d         = ~rd_bank_q;
                            rcnt_d            = '0;
                            r_state_d         = R_IDLE;
                        end else begin
                            rcnt_d = rcnt_q + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            mod_q       <= 2'd0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            sym_done_q  <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            mod_q       <= mod_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            sym_done_q  <= sym_done_d;
        end
    end

endmodule

// File: tb/tb_deint_ctrl.sv
// Self-checking bench for deint_ctrl.
// Scoreboard of expected reads, filled as banks complete.
module tb_deint_ctrl;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [1:0]        mod = 2'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic              sym_done;
    logic              busy;

    deint_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mod       (mod),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_addr   (wr_addr),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .sym_done  (sym_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bank;
        int         addr;
        logic       last;
    } rd_t;

    typedef struct {
        logic [1:0] mod;
        int         n;
    } vec_t;

    rd_t  rdq[$];
    vec_t tbl[4];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   cur_n = 48;
    int   exp_waddr = 0;
    logic exp_wbank = 1'b0;
    logic prev_rd = 1'b0;
    logic prev_last = 1'b0;
    int   fill_cyc = 0;
    int   first_lat = -1;
    int   n_wr = 0;
    int   n_rd = 0;
    int   n_ov = 0;
    int   n_sd = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: sample at negedge, score, return 1 after posedge.
    task automatic cycle();
        rd_t e;
        logic cur_rd;
        logic cur_last;
        @(negedge clk);
        cyc++;
        if (rst) begin
            rdq.delete();
            prev_rd   = 1'b0;
            prev_last = 1'b0;
            exp_waddr = 0;
            exp_wbank = 1'b0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(prev_rd));
            chk("sym_done", 32'(sym_done), 32'(prev_rd & prev_last));
            if (out_valid) n_ov++;
            if (sym_done) n_sd++;
            if (wr_en) begin
                chk("wr_addr", 32'(wr_addr), exp_waddr);
                chk("wr_bank", 32'(wr_bank), 32'(exp_wbank));
                n_wr++;
                if (exp_waddr == cur_n - 1) begin
                    for (int i = 0; i < cur_n; i++)
                        rdq.push_back('{bank: exp_wbank, addr: i,
                                        last: (i == cur_n - 1)});
                    exp_waddr = 0;
                    exp_wbank = ~exp_wbank;
                    fill_cyc  = cyc;
                end else begin
                    exp_waddr++;
                end
            end
            cur_rd   = 1'b0;
            cur_last = 1'b0;
            if (rd_en) begin
                cur_rd = 1'b1;
                n_rd++;
                if (rdq.size() == 0) begin
                    chk("rd_unexpected", 32'(rd_addr), 32'hFFFF_FFFF);
                end else begin
                    e = rdq.pop_front();
                    chk("rd_bank", 32'(rd_bank), 32'(e.bank));
                    chk("rd_addr", 32'(rd_addr), e.addr);
                    cur_last = e.last;
                    if (e.addr == 0) first_lat = cyc - fill_cyc;
                end
            end
            prev_rd   = cur_rd;
            prev_last = cur_last;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cycle();
        cycle();
        rst   = 1'b0;
        n_wr  = 0;
        n_rd  = 0;
        n_ov  = 0;
        n_sd  = 0;
        first_lat = -1;
    endtask

    task automatic do_start(input logic [1:0] m, input int n);
        mod   = m;
        cur_n = n;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic wait_reads(input int target, input int budget,
                              input string nm);
        int k;
        k = 0;
        while (n_rd < target && k < budget) begin
            cycle();
            k++;
        end
        chk(nm, n_rd, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{mod: 2'd0, n: 48};
        tbl[1] = '{mod: 2'd1, n: 96};
        tbl[2] = '{mod: 2'd2, n: 192};
        tbl[3] = '{mod: 2'd3, n: 288};

        #1;
        do_reset();

        // Idle after reset: inputs toggling but no start.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        stop      = 1'b1;
        cycle();
        cycle();
        stop = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_busy", 32'(busy), 0);

        // Reset in the middle of fill and drain.
        in_valid  = 1'b0;
        out_ready = 1'b0;
        do_start(2'd0, 48);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 60; k++) cycle();
        rst   = 1'b1;
        start = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        start = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_rd_en", 32'(rd_en), 0);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_sym_done", 32'(sym_done), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        cycle();
        chk("post_rst_busy", 32'(busy), 0);

        // One full symbol per modulation, continuous input and output.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            do_start(tbl[i].mod, tbl[i].n);
            mod       = tbl[(i + 1) % 4].mod;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            for (int k = 0; k < tbl[i].n; k++) cycle();
            in_valid = 1'b0;
            wait_reads(tbl[i].n, tbl[i].n + 10, "tbl_reads");
            cycle();
            cycle();
            chk("tbl_writes", n_wr, tbl[i].n);
            chk("tbl_out_valid", n_ov, tbl[i].n);
            chk("tbl_sym_done", n_sd, 1);
            chk("tbl_latency", first_lat, 2);
            chk("tbl_busy_fill", 32'(busy), 1);
            chk("tbl_in_ready", 32'(in_ready), 1);
            chk("tbl_wr_bank", 32'(wr_bank), 1);
            do_stop();
            chk("tbl_busy_stop", 32'(busy), 0);
            chk("tbl_in_ready_stop", 32'(in_ready), 0);
        end

        // Backpressure: both banks fill, then input stalls.
        do_reset();
        do_start(2'd3, 288);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 600; k++) cycle();
        chk("bp_accepted", n_wr, 576);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_no_reads", n_rd, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_reads(288, 300, "bp_bank0_reads");
        chk("bp_in_ready_free", 32'(in_ready), 1);
        chk("bp_wr_bank", 32'(wr_bank), 0);
        chk("bp_bubble", 32'(rd_en), 0);
        wait_reads(576, 300, "bp_bank1_reads");
        cycle();
        cycle();
        chk("bp_sym_done", n_sd, 2);
        do_stop();
        chk("bp_busy_end", 32'(busy), 0);

        // Mod change and start pulse mid-frame are ignored.
        do_reset();
        do_start(2'd1, 96);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 192; k++) begin
            if (k == 50) begin
                mod   = 2'd2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            cycle();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        wait_reads(192, 250, "ign_reads");
        cycle();
        cycle();
        chk("ign_writes", n_wr, 192);
        chk("ign_sym_done", n_sd, 2);
        chk("ign_out_valid", n_ov, 192);
        do_stop();

        // Stop mid-fill with bank1 full.
        do_reset();
        do_start(2'd1, 96);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 192; k++) cycle();
        chk("sf_writes_full", n_wr, 192);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_reads(96, 110, "sf_bank0_reads");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 20; k++) cycle();
        chk("sf_partial_writes", n_wr, 212);
        chk("sf_wcnt", 32'(wr_addr), 20);
        in_valid = 1'b0;
        do_stop();
        exp_waddr = 0;
        chk("sf_busy_after_stop", 32'(busy), 1);
        out_ready = 1'b1;
        wait_reads(192, 120, "sf_bank1_reads");
        chk("sf_last_out_valid", 32'(out_valid), 1);
        chk("sf_busy_last", 32'(busy), 1);
        cycle();
        chk("sf_busy_fall", 32'(busy), 0);
        for (int k = 0; k < 10; k++) cycle();
        chk("sf_no_extra_reads", n_rd, 192);
        chk("sf_sym_done", n_sd, 2);

        // Last write of bank1 coincides with last read of bank0.
        do_reset();
        do_start(2'd0, 48);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 48; k++) cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 48; k++) cycle();
        in_valid = 1'b0;
        chk("sim_reads_b0", n_rd, 48);
        chk("sim_writes", n_wr, 96);
        chk("sim_in_ready", 32'(in_ready), 1);
        chk("sim_wr_bank", 32'(wr_bank), 0);
        chk("sim_rd_bank", 32'(rd_bank), 1);
        chk("sim_bubble", 32'(rd_en), 0);
        chk("sim_busy", 32'(busy), 1);
        wait_reads(96, 60, "sim_reads_b1");
        cycle();
        cycle();
        chk("sim_sym_done", n_sd, 2);
        do_stop();
        chk("sim_busy_end", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/deint_ctrl.md
DEINT_CTRL -- requirements
Module: deint_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9: width of the buffer address and the symbol counters.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1: begin a frame and latch mod.
REQ-005 SHALL have port stop, input, 1: end a frame.
REQ-006 SHALL have port mod, input, 2: 0=BPSK, 1=QPSK, 2=16QAM, 3=64QAM.
REQ-007 SHALL have port in_valid, input, 1: coded bit is present upstream.
REQ-008 SHALL have port in_ready, output, 1: controller accepts a bit this cycle.
REQ-009 SHALL have ports wr_en (output, 1), wr_bank (output, 1) and wr_addr (output, ADDR_W): write strobe, bank and address of the ping-pong buffer.
REQ-010 SHALL have ports rd_en (output, 1), rd_bank (output, 1) and rd_addr (output, ADDR_W): read strobe, bank and address of the ping-pong buffer.
REQ-011 SHALL have port out_ready, input, 1: downstream permits a read this cycle.
REQ-012 SHALL have ports out_valid (output, 1), sym_done (output, 1) and busy (output, 1): buffer data valid, last bit of symbol, and frame in progress.

Function
REQ-013 SHALL set N_CBPS from latched mod_r: 48, 96, 192 or 288; terminal count N_CBPS-1 is 47, 95, 191 or 287.
REQ-014 SHALL latch mod and clear wcnt, rcnt, wr_bank, rd_bank and full[1:0] on start only when busy=0; start while busy=1 SHALL be ignored.
REQ-015 SHALL ignore changes on mod except at an accepted start.
REQ-016 SHALL implement write FSM W_IDLE/W_FILL: accepted start -> W_FILL; stop -> W_IDLE.
REQ-017 SHALL drive in_ready = (W_FILL and full[wr_bank]=0) combinationally.
REQ-018 SHALL drive wr_en = in_valid and in_ready, with wr_addr = wcnt.
REQ-019 SHALL increment wcnt on each write; a write at wcnt=N_CBPS-1 SHALL set full[wr_bank], toggle wr_bank and clear wcnt at the same edge.
REQ-020 SHALL, on stop in W_FILL, discard a partially filled bank (wcnt cleared, full unchanged); full banks SHALL still drain.
REQ-021 SHALL implement read FSM R_IDLE/R_DRAIN: R_IDLE -> R_DRAIN at an edge where registered full[rd_bank]=1.
REQ-022 SHALL drive rd_en = (R_DRAIN and out_ready), with rd_addr = rcnt.
REQ-023 SHALL increment rcnt on each read; a read at rcnt=N_CBPS-1 SHALL clear full[rd_bank], toggle rd_bank, clear rcnt and return to R_IDLE (one bubble cycle even if the other bank is full).
REQ-024 SHALL register out_valid = rd_en delayed by 1 cycle, matching the buffer's 1-cycle read latency.
REQ-025 SHALL require downstream to accept every out_valid; out_ready gates issue one cycle ahead.
REQ-026 SHALL assert sym_done for 1 cycle, coincident with the out_valid of the read at rcnt=N_CBPS-1.
REQ-027 SHALL allow a full-set (write bank) and a full-clear (read bank) in the same edge; they always target different banks and SHALL both take effect.
REQ-028 SHALL drive busy = (W_FILL) or full[0] or full[1] or R_DRAIN or out_valid.
REQ-029 SHALL give latency from the accepted last write to the first possible rd_en of 2 cycles.

Reset
REQ-030 SHALL, with rst=1 at an edge (including mid-fill or mid-drain), set FSMs to W_IDLE/R_IDLE, all counters, banks and full to 0, and mod_r=0.
REQ-031 SHALL hold in_ready, wr_en, rd_en, out_valid, sym_done and busy at 0 after reset until an accepted start.
REQ-032 SHALL give rst priority over start, stop and all data events in the same cycle.

Verification
REQ-033 SHALL be verified for reset: rst=1 for 2 cycles during activity -> all outputs 0, busy=0.
REQ-034 SHALL be verified for BPSK: mod=0, start, 48 continuous bits, out_ready=1 -> wr_addr 0..47 on bank0; rd_en 2 cycles after last write; rd_addr 0..47 on bank0; sym_done with 48th out_valid.
REQ-035 SHALL be verified for backpressure: mod=3, out_ready=0, 600 bits offered -> exactly 576 accepted, then in_ready=0; raise out_ready -> 288 reads from bank0, then in_ready=1 on bank0.
REQ-036 SHALL be verified for ignored controls: mod changed to 2 and start pulsed mid-frame under mod=1 -> symbols stay 96 bits, no pointer clear.
REQ-037 SHALL be verified for stop mid-fill: stop at wcnt=20 with bank1 full -> bank1 drains with 96 reads, partial bank0 never read, busy falls after last out_valid.
REQ-038 SHALL be verified for simultaneous events: last write to bank1 in the same cycle as last read of bank0 -> full=2'b10 after the edge.
